// File: rtl/flag_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flag_pkg
// Purpose  : Shared constants for the status-flag unit: flag bit positions,
//            branch condition codes and the default sticky-mode mask.
// Revision : 1.0 - initial release
// ============================================================================
package flag_pkg;

  // Flag bit positions inside FLAG_OUT
  localparam int c_FLAG_C = 0;
  localparam int c_FLAG_Z = 1;
  localparam int c_FLAG_B = 2;
  localparam int c_FLAG_N = 3;

  // Branch condition codes (COND_SEL encoding)
  localparam logic [3:0] c_COND_ALWAYS = 4'd0;
  localparam logic [3:0] c_COND_EQ     = 4'd1;
  localparam logic [3:0] c_COND_NE     = 4'd2;
  localparam logic [3:0] c_COND_CS     = 4'd3;
  localparam logic [3:0] c_COND_CC     = 4'd4;
  localparam logic [3:0] c_COND_BS     = 4'd5;
  localparam logic [3:0] c_COND_BC     = 4'd6;
  localparam logic [3:0] c_COND_MI     = 4'd7;
  localparam logic [3:0] c_COND_PL     = 4'd8;

  // Carry and borrow accumulate; zero and negative follow the ALU
  localparam logic [3:0] c_STICKY_MASK_DEFAULT = 4'b0101;

endpackage : flag_pkg
`default_nettype wire

// File: rtl/flag_stack.sv
`default_nettype none
// ============================================================================
// Module   : flag_stack
// Purpose  : Small LIFO for saved flag words. Supports push, pop and a
//            simultaneous push+pop swap of the top entry. Full/empty are
//            registered alongside the pointer; o_err pulses on an
//            overflowing push or underflowing pop.
// Revision : 1.0 - initial release
// ============================================================================
module flag_stack
  import flag_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_data,
  output logic [WIDTH-1:0] o_top,
  output logic             o_pop_vld,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_err
);

  localparam int c_PW = $clog2(DEPTH + 1);
  localparam int c_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_PW-1:0] c_PTR_MAX = c_PW'(DEPTH);

  logic [WIDTH-1:0] r_mem [0:(2**c_AW)-1];
  logic [c_PW-1:0]  r_ptr;
  logic [c_PW-1:0]  w_ptr_nxt;
  logic             r_full;
  logic             r_empty;
  logic [c_AW-1:0]  w_top_idx;
  logic [c_AW-1:0]  w_wr_idx;
  logic             w_swap;
  logic             w_push_do;
  logic             w_pop_do;
  logic             w_wr_en;

  // Push+pop on an empty stack degrades to a plain push
  assign w_swap    = i_push & i_pop & ~r_empty;
  assign w_push_do = i_push & ~w_swap & ~r_full;
  assign w_pop_do  = i_pop & ~i_push & ~r_empty;
  assign w_wr_en   = w_swap | w_push_do;

  assign w_top_idx = c_AW'(r_ptr - c_PW'(1));
  assign w_wr_idx  = w_swap ? w_top_idx : c_AW'(r_ptr);

  assign o_top     = r_mem[w_top_idx];
  assign o_pop_vld = w_swap | w_pop_do;
  assign o_err     = (i_push & ~i_pop & r_full) | (i_pop & ~i_push & r_empty);
  assign o_full    = r_full;
  assign o_empty   = r_empty;

  // Pointer next-state: a swap leaves the depth unchanged
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_push_do) begin
      w_ptr_nxt = r_ptr + c_PW'(1);
    end else if (w_pop_do) begin
      w_ptr_nxt = r_ptr - c_PW'(1);
    end
  end

  // Pointer and its registered full/empty decodes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_full  <= (w_ptr_nxt == c_PTR_MAX);
      r_empty <= (w_ptr_nxt == '0);
    end
  end

  // Entry storage; contents are meaningless above the pointer
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

endmodule : flag_stack
`default_nettype wire

// File: rtl/flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : flag_unit
// Purpose  : Parametrised status-flag register with per-bit level/sticky
//            update, per-bit clear and a save/restore flag stack.
//            Optional branch-condition decode enabled by FLAG_UNIT_COND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module flag_unit
  import flag_pkg::*;
#(
  parameter int                NFLAGS      = 4,
  parameter logic [NFLAGS-1:0] STICKY_MASK = NFLAGS'(c_STICKY_MASK_DEFAULT),
  parameter int                STK_DEPTH   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NFLAGS-1:0] FLAG_IN,
  input  logic [NFLAGS-1:0] FLAG_WE,
  input  logic [NFLAGS-1:0] FLAG_CLR,
  input  logic              PUSH,
  input  logic              POP,
  output logic [NFLAGS-1:0] FLAG_OUT,
  output logic              STK_FULL,
  output logic              STK_EMPTY,
  output logic              STK_ERR
`ifdef FLAG_UNIT_COND_EN
  ,
  input  logic [3:0]        COND_SEL,
  output logic              COND_TRUE
`endif
);

  logic [NFLAGS-1:0] r_flags;
  logic [NFLAGS-1:0] w_bit_upd;
  logic [NFLAGS-1:0] w_flags_nxt;
  logic [NFLAGS-1:0] w_top;
  logic              w_pop_vld;
  logic              w_stk_err;
  logic              r_stk_err;

  flag_stack #(
    .WIDTH (NFLAGS),
    .DEPTH (STK_DEPTH)
  ) u_stack (
    .clk       (CLK),
    .rst_n     (RST),
    .i_push    (PUSH),
    .i_pop     (POP),
    .i_data    (r_flags),
    .o_top     (w_top),
    .o_pop_vld (w_pop_vld),
    .o_full    (STK_FULL),
    .o_empty   (STK_EMPTY),
    .o_err     (w_stk_err)
  );

  // Per-bit update: clear beats write; sticky bits OR in, level bits follow
  for (genvar gi = 0; gi < NFLAGS; gi++) begin : g_bit
    assign w_bit_upd[gi] = FLAG_CLR[gi] ? 1'b0 :
                           !FLAG_WE[gi] ? r_flags[gi] :
                           STICKY_MASK[gi] ? (r_flags[gi] | FLAG_IN[gi]) :
                           FLAG_IN[gi];
  end : g_bit

  // A valid restore overrides every per-bit write and clear
  assign w_flags_nxt = w_pop_vld ? w_top : w_bit_upd;

  // Flag register and sticky stack-error latch
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_flags   <= '0;
      r_stk_err <= 1'b0;
    end else begin
      r_flags   <= w_flags_nxt;
      r_stk_err <= r_stk_err | w_stk_err;
    end
  end

  assign FLAG_OUT = r_flags;
  assign STK_ERR  = r_stk_err;

`ifdef FLAG_UNIT_COND_EN
  // Branch condition decode from the registered flags
  always_comb begin
    COND_TRUE = 1'b0;
    case (COND_SEL)
      c_COND_ALWAYS: COND_TRUE = 1'b1;
      c_COND_EQ:     COND_TRUE = r_flags[c_FLAG_Z];
      c_COND_NE:     COND_TRUE = ~r_flags[c_FLAG_Z];
      c_COND_CS:     COND_TRUE = r_flags[c_FLAG_C];
      c_COND_CC:     COND_TRUE = ~r_flags[c_FLAG_C];
      c_COND_BS:     COND_TRUE = r_flags[c_FLAG_B];
      c_COND_BC:     COND_TRUE = ~r_flags[c_FLAG_B];
      c_COND_MI:     COND_TRUE = r_flags[c_FLAG_N];
      c_COND_PL:     COND_TRUE = ~r_flags[c_FLAG_N];
      default:       COND_TRUE = 1'b0;
    endcase
  end
`endif

endmodule : flag_unit
`default_nettype wire

// File: tb/tb_flag_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_flag_unit
// Purpose  : Self-checking bench for flag_unit (NFLAGS=4, STK_DEPTH=4).
//            Condition-decode checks compile in with FLAG_UNIT_COND_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_flag_unit;

  localparam logic [3:0] c_MASK  = 4'b0101;
  localparam int         c_DEPTH = 4;

  logic       CLK;
  logic       RST;
  logic [3:0] FLAG_IN;
  logic [3:0] FLAG_WE;
  logic [3:0] FLAG_CLR;
  logic       PUSH;
  logic       POP;
  logic [3:0] FLAG_OUT;
  logic       STK_FULL;
  logic       STK_EMPTY;
  logic       STK_ERR;
`ifdef FLAG_UNIT_COND_EN
  logic [3:0] COND_SEL;
  logic       COND_TRUE;
`endif

  int n_vec;
  int n_err;

  // Reference model state
  logic [3:0] m_flags;
  logic [3:0] m_stk [0:c_DEPTH-1];
  int         m_ptr;
  logic       m_err;

  logic [6:0] sb_q [$];

  flag_unit #(
    .NFLAGS      (4),
    .STICKY_MASK (c_MASK),
    .STK_DEPTH   (c_DEPTH)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .FLAG_IN   (FLAG_IN),
    .FLAG_WE   (FLAG_WE),
    .FLAG_CLR  (FLAG_CLR),
    .PUSH      (PUSH),
    .POP       (POP),
    .FLAG_OUT  (FLAG_OUT),
    .STK_FULL  (STK_FULL),
    .STK_EMPTY (STK_EMPTY),
    .STK_ERR   (STK_ERR)
`ifdef FLAG_UNIT_COND_EN
    ,
    .COND_SEL  (COND_SEL),
    .COND_TRUE (COND_TRUE)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [6:0] m_word();
    return {m_flags, (m_ptr == c_DEPTH), (m_ptr == 0), m_err};
  endfunction

  task automatic m_reset();
    m_flags = 4'b0;
    m_ptr   = 0;
    m_err   = 1'b0;
  endtask

  // Behavioural model of one clock edge
  task automatic m_step(input logic [3:0] we, input logic [3:0] in, input logic [3:0] clr,
                        input logic push, input logic pop);
    logic [3:0] old;
    logic       pop_ok;
    old    = m_flags;
    pop_ok = pop && (m_ptr > 0);
    if ((push && !pop && m_ptr == c_DEPTH) || (pop && !push && m_ptr == 0))
      m_err = 1'b1;
    if (pop_ok) begin
      m_flags = m_stk[m_ptr-1];
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (clr[b])           m_flags[b] = 1'b0;
        else if (we[b] && c_MASK[b]) m_flags[b] = old[b] | in[b];
        else if (we[b])       m_flags[b] = in[b];
      end
    end
    if (push && pop_ok) begin
      m_stk[m_ptr-1] = old;
    end else if (push && m_ptr < c_DEPTH) begin
      m_stk[m_ptr] = old;
      m_ptr++;
    end else if (pop_ok) begin
      m_ptr--;
    end
  endtask

  // Drive one cycle of stimulus, predict, then compare after the edge
  task automatic step(input logic [3:0] we, input logic [3:0] in, input logic [3:0] clr,
                      input logic push, input logic pop, input string tag);
    logic [6:0] exp;
    @(negedge CLK);
    FLAG_WE  = we;
    FLAG_IN  = in;
    FLAG_CLR = clr;
    PUSH     = push;
    POP      = pop;
    m_step(we, in, clr, push, pop);
    sb_q.push_back(m_word());
    @(posedge CLK);
    #1;
    exp = sb_q.pop_front();
    chk(tag, {25'b0, FLAG_OUT, STK_FULL, STK_EMPTY, STK_ERR}, {25'b0, exp});
    FLAG_WE  = 4'b0;
    FLAG_CLR = 4'b0;
    PUSH     = 1'b0;
    POP      = 1'b0;
  endtask

  // Load an exact flag value: clear everything, then write all bits
  task automatic load(input logic [3:0] v);
    step(4'b0000, 4'b0000, 4'b1111, 1'b0, 1'b0, "load_clr");
    step(4'b1111, v, 4'b0000, 1'b0, 1'b0, "load_wr");
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    RST      = 1'b0;
    FLAG_IN  = 4'b0;
    FLAG_WE  = 4'b0;
    FLAG_CLR = 4'b0;
    PUSH     = 1'b0;
    POP      = 1'b0;
`ifdef FLAG_UNIT_COND_EN
    COND_SEL = 4'd0;
`endif
    m_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset", {25'b0, FLAG_OUT, STK_FULL, STK_EMPTY, STK_ERR}, 32'b0000_0_1_0);
    @(negedge CLK);
    RST = 1'b1;

    // Level update on Z
    step(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0, "level_set");
    chk("level_set_val", {28'b0, FLAG_OUT}, 32'h2);
    step(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, "level_clr");

    // Sticky behaviour on C
    step(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, "sticky_set");
    step(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, "sticky_hold");
    chk("sticky_hold_val", {28'b0, FLAG_OUT}, 32'h1);
    step(4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0, "sticky_clr");
    step(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0, "sticky_set2");
    step(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0, "clr_beats_we");
    chk("clr_beats_we_val", {28'b0, FLAG_OUT}, 32'h0);

    // Fill the stack with 1..4
    for (int v = 1; v <= 4; v++) begin
      load(4'(v));
      step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, "push");
    end
    chk("full_flag", {31'b0, STK_FULL}, 32'h1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, "push_overflow");
    chk("overflow_err", {31'b0, STK_ERR}, 32'h1);

    // Drain in reverse order
    for (int v = 4; v >= 1; v--) begin
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, "pop");
      chk("pop_val", {28'b0, FLAG_OUT}, 32'(v));
    end
    chk("empty_flag", {31'b0, STK_EMPTY}, 32'h1);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, "pop_underflow");
    chk("underflow_hold", {28'b0, FLAG_OUT}, 32'h1);

    // Swap: top=0011, flags=1000
    load(4'b0011);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, "swap_push");
    load(4'b1000);
    step(4'b1111, 4'b0110, 4'b0000, 1'b1, 1'b1, "swap");
    chk("swap_val", {28'b0, FLAG_OUT}, 32'h3);
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, "swap_top");
    chk("swap_top_val", {28'b0, FLAG_OUT}, 32'h8);

    // Push+pop on empty behaves as push with same-cycle write
    step(4'b0010, 4'b0010, 4'b0000, 1'b1, 1'b1, "pushpop_empty");
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, "pushpop_empty_pop");

    // Push with a concurrent flag write
    load(4'b0101);
    step(4'b1010, 4'b1010, 4'b0000, 1'b1, 1'b0, "push_with_wr");
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, "push_with_wr_pop");

`ifdef FLAG_UNIT_COND_EN
    load(4'b0010);
    COND_SEL = 4'd1;
    #1 chk("cond_eq", {31'b0, COND_TRUE}, 32'h1);
    COND_SEL = 4'd2;
    #1 chk("cond_ne", {31'b0, COND_TRUE}, 32'h0);
    COND_SEL = 4'd12;
    #1 chk("cond_12", {31'b0, COND_TRUE}, 32'h0);
    COND_SEL = 4'd0;
    #1 chk("cond_always", {31'b0, COND_TRUE}, 32'h1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 80; i++) begin
      step(4'($urandom), 4'($urandom), 4'($urandom_range(0, 3) == 0 ? $urandom : 0),
           1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0), "random");
    end

    // Asynchronous reset with two entries on the stack
    for (int i = 0; i < c_DEPTH; i++)
      step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, "drain");
    load(4'b1011);
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, "pre_rst_push1");
    step(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, "pre_rst_push2");
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("async_rst", {25'b0, FLAG_OUT, STK_FULL, STK_EMPTY, STK_ERR}, 32'b0000_0_1_0);
    m_reset();
    @(negedge CLK);
    RST = 1'b1;
    step(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, "post_rst_pop");
    step(4'b0100, 4'b0100, 4'b0000, 1'b1, 1'b0, "post_rst_push");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_flag_unit
`default_nettype wire
